// File: rtl/rle_pkg.sv
// Shared definitions for the run-length token stream: token field layout and encoder states.
`ifndef RLE_PKG_SV
`define RLE_PKG_SV
`define TOKEN_W(sym_w, len_w) (2 + (sym_w) + (len_w))

package rle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } rle_state_t;

  localparam int LEN_LSB = 0;

  function automatic int token_w(input int sym_w, input int len_w);
    return `TOKEN_W(sym_w, len_w);
  endfunction

  function automatic int sym_lsb(input int len_w);
    return len_w;
  endfunction

  function automatic int eol_bit(input int sym_w, input int len_w);
    return sym_w + len_w;
  endfunction

  function automatic int eof_bit(input int sym_w, input int len_w);
    return sym_w + len_w + 1;
  endfunction

endpackage
`endif

// File: rtl/rle_token_fifo.sv
// Synchronous FIFO for run tokens; output is valid whenever the FIFO is non-empty.
module rle_token_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  // Empty FIFO presents an all-zero word so the output is defined out of reset.
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/rle_stream_encoder.sv
// Run-length encoder for class-label pixel streams; runs close on symbol change,
// length saturation, line end, end of frame, or an unexpected start of frame.
module rle_stream_encoder
  import rle_pkg::*;
#(
  parameter int SYM_W  = 2,
  parameter int LEN_W  = 10,
  parameter int LINE_W = 640,
  parameter int DEPTH  = 8
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic [SYM_W-1:0]                 in_sym,
  input  logic                             in_valid,
  input  logic                             in_sop,
  input  logic                             in_eop,
  output logic                             in_ready,
  output logic [token_w(SYM_W, LEN_W)-1:0] out_token,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             frame_err,
  output logic [$clog2(DEPTH):0]           fifo_level
);
  localparam int TW    = token_w(SYM_W, LEN_W);
  localparam int XW    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int EOF_B = eof_bit(SYM_W, LEN_W);
  localparam int EOL_B = eol_bit(SYM_W, LEN_W);
  localparam int SYM_L = sym_lsb(LEN_W);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [XW-1:0]    X_LAST  = XW'(LINE_W - 1);

  rle_state_t       r_state, w_state_next;
  logic [SYM_W-1:0] r_run_sym, w_run_sym_next;
  logic [LEN_W-1:0] r_run_len, w_run_len_next;
  logic [XW-1:0]    r_x, w_x_next, w_x_cur;
  logic             r_eof_pend, w_eof_pend_next;
  logic             r_frame_err, w_frame_err_next;
  logic             w_accept;
  logic             w_push;
  logic [TW-1:0]    w_push_tok;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  function automatic logic [TW-1:0] pack_token(input logic eof, input logic eol,
                                               input logic [SYM_W-1:0] sym,
                                               input logic [LEN_W-1:0] len);
    logic [TW-1:0] tok;
    tok                    = '0;
    tok[EOF_B]             = eof;
    tok[EOL_B]             = eol;
    tok[SYM_L +: SYM_W]    = sym;
    tok[LEN_LSB +: LEN_W]  = len;
    return tok;
  endfunction

  assign in_ready  = (r_state != ST_FLUSH) && !w_fifo_full;
  assign w_accept  = in_valid && in_ready;
  assign w_x_cur   = in_sop ? '0 : r_x;
  assign out_valid = !w_fifo_empty;
  assign frame_err = r_frame_err;

  always_comb begin
    w_state_next     = r_state;
    w_run_sym_next   = r_run_sym;
    w_run_len_next   = r_run_len;
    w_x_next         = r_x;
    w_eof_pend_next  = r_eof_pend;
    w_frame_err_next = 1'b0;
    w_push           = 1'b0;
    w_push_tok       = '0;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (w_accept) begin
          w_run_sym_next = in_sym;
          w_run_len_next = LEN_W'(1);
          if (r_state == ST_RUN) begin
            if (in_sop) begin
              // Start of frame inside an open run: close it as a truncated frame.
              w_push           = 1'b1;
              w_push_tok       = pack_token(1'b1, 1'b1, r_run_sym, r_run_len);
              w_frame_err_next = 1'b1;
            end else if ((in_sym == r_run_sym) && (r_run_len != LEN_MAX)) begin
              w_run_len_next = r_run_len + 1'b1;
            end else begin
              w_push     = 1'b1;
              w_push_tok = pack_token(1'b0, 1'b0, r_run_sym, r_run_len);
            end
          end
          if (in_eop || (w_x_cur == X_LAST)) begin
            w_state_next    = ST_FLUSH;
            w_x_next        = '0;
            w_eof_pend_next = in_eop;
          end else begin
            w_state_next = ST_RUN;
            w_x_next     = w_x_cur + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (!w_fifo_full) begin
          w_push          = 1'b1;
          w_push_tok      = pack_token(r_eof_pend, 1'b1, r_run_sym, r_run_len);
          w_state_next    = ST_IDLE;
          w_run_sym_next  = '0;
          w_run_len_next  = '0;
          w_eof_pend_next = 1'b0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_run_sym   <= '0;
      r_run_len   <= '0;
      r_x         <= '0;
      r_eof_pend  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_run_sym   <= w_run_sym_next;
      r_run_len   <= w_run_len_next;
      r_x         <= w_x_next;
      r_eof_pend  <= w_eof_pend_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  rle_token_fifo #(
    .WIDTH(TW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_push  (w_push),
    .i_data  (w_push_tok),
    .i_pop   (out_ready),
    .o_data  (out_token),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (fifo_level)
  );

endmodule

// File: tb/tb_rle_stream_encoder.sv
// Randomised bench for rle_stream_encoder against a pixel-by-pixel run-length reference model.
module tb_rle_stream_encoder;
  localparam int SYM_W = 2, LEN_W = 4, LINE_W = 8, DEPTH = 4;
  localparam int MAXLEN = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] in_sym;
  logic       in_valid, in_sop, in_eop, in_ready;
  logic [7:0] out_token;
  logic       out_valid, out_ready, frame_err;
  logic [2:0] fifo_level;

  logic [1:0] b_sym;
  logic       b_valid, b_sop, b_eop, b_in_ready;
  logic [6:0] b_token;
  logic       b_out_valid, b_out_ready, b_frame_err;
  logic [2:0] b_level;

  always #5 clk = ~clk;

  rle_stream_encoder #(.SYM_W(SYM_W), .LEN_W(LEN_W), .LINE_W(LINE_W), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST_N(rst_n), .in_sym(in_sym), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_ready(in_ready), .out_token(out_token), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .fifo_level(fifo_level));

  rle_stream_encoder #(.SYM_W(2), .LEN_W(3), .LINE_W(8), .DEPTH(4)) dut_sat (
    .CLK(clk), .RST_N(rst_n), .in_sym(b_sym), .in_valid(b_valid), .in_sop(b_sop),
    .in_eop(b_eop), .in_ready(b_in_ready), .out_token(b_token), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .frame_err(b_frame_err), .fifo_level(b_level));

  int n_vec = 0;
  int n_err = 0;

  // Monitor: the only writer of the observed-token queues and error-pulse counters.
  logic [7:0] got_q[$];
  logic [6:0] got_b_q[$];
  int err_pulses = 0;
  int b_err_pulses = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_q.push_back(out_token);
        $display("token %0d: eof=%0d eol=%0d sym=%0d len=%0d", got_q.size() - 1,
                 out_token[7], out_token[6], out_token[5:4], out_token[3:0]);
      end
      if (b_out_valid && b_out_ready) got_b_q.push_back(b_token);
      if (frame_err) err_pulses++;
      if (b_frame_err) b_err_pulses++;
    end
  end

  // Reference model: pixel-level run-length rules.
  logic [7:0] exp_q[$];
  int  exp_err = 0;
  bit  m_open = 0;
  int  m_sym = 0, m_len = 0, m_col = 0;

  function automatic logic [7:0] mk(input bit eof, input bit eol, input int s, input int l);
    return {eof, eol, s[1:0], l[3:0]};
  endfunction

  task automatic model_reset();
    m_open = 0; m_sym = 0; m_len = 0; m_col = 0;
    exp_q.delete(); exp_err = 0;
  endtask

  task automatic model_pixel(input int s, input bit sop, input bit eop);
    if (sop) begin
      m_col = 0;
      if (m_open) begin
        exp_q.push_back(mk(1, 1, m_sym, m_len));
        exp_err++;
        m_open = 0;
      end
    end
    if (m_open && s == m_sym && m_len < MAXLEN) m_len++;
    else begin
      if (m_open) exp_q.push_back(mk(0, 0, m_sym, m_len));
      m_sym = s; m_len = 1; m_open = 1;
    end
    if (eop || m_col == LINE_W - 1) begin
      exp_q.push_back(mk(eop, 1, m_sym, m_len));
      m_open = 0; m_col = 0;
    end else m_col++;
  endtask

  // Presents one pixel and leaves it on the bus until the cycle after acceptance.
  task automatic send_pixel(input int s, input bit sop, input bit eop);
    int waited = 0;
    in_sym = 2'(s); in_sop = sop; in_eop = eop; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    n_vec++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL send_timeout: in_ready=%0d after %0d cycles, required 1", in_ready, waited);
    end else model_pixel(s, sop, eop);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec += 4;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0d, required 0", out_valid); end
    if (out_token !== 8'h00) begin n_err++; $display("FAIL reset_out_token: got %h, required 00", out_token); end
    if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %0d, required 0", frame_err); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0d, required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic send_line_frame();
    int syms[8] = '{1, 1, 1, 2, 2, 0, 0, 0};
    for (int i = 0; i < 8; i++) send_pixel(syms[i], i == 0, i == 7);
    drain();
  endtask

  task automatic test_line();
    int gb = got_q.size(); int eb = err_pulses;
    send_line_frame();
    n_vec += 2;
    if (got_q.size() - gb != exp_q.size()) begin n_err++; $display("FAIL line_count: got %0d, required %0d", got_q.size() - gb, exp_q.size()); end
    if (err_pulses - eb != exp_err) begin n_err++; $display("FAIL line_frame_err: got %0d, required %0d", err_pulses - eb, exp_err); end
    for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[gb + i] !== exp_q[i]) begin n_err++; $display("FAIL line_tok%0d: got %h, required %h", i, got_q[gb + i], exp_q[i]); end
    end
    model_reset();
  endtask

  task automatic test_line_cut();
    int gb = got_q.size();
    for (int i = 0; i < 20; i++) send_pixel(3, i == 0, i == 19);
    drain();
    n_vec++;
    if (got_q.size() - gb != exp_q.size()) begin n_err++; $display("FAIL cut_count: got %0d, required %0d", got_q.size() - gb, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[gb + i] !== exp_q[i]) begin n_err++; $display("FAIL cut_tok%0d: got %h, required %h", i, got_q[gb + i], exp_q[i]); end
    end
    model_reset();
  endtask

  task automatic test_saturation();
    logic [6:0] exp_b[2];
    int gb = got_b_q.size(); int eb = b_err_pulses; int waited;
    exp_b[0] = {1'b0, 1'b0, 2'd3, 3'd7};
    exp_b[1] = {1'b1, 1'b1, 2'd3, 3'd1};
    for (int i = 0; i < 8; i++) begin
      b_sym = 2'd3; b_sop = (i == 0); b_eop = (i == 7); b_valid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!b_in_ready && waited < 200) begin waited++; @(negedge clk); end
      @(posedge clk); #1;
    end
    b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_vec += 3;
    if (got_b_q.size() - gb != 2) begin n_err++; $display("FAIL sat_count: got %0d, required 2", got_b_q.size() - gb); end
    if (b_err_pulses != eb) begin n_err++; $display("FAIL sat_frame_err: got %0d pulses, required 0", b_err_pulses - eb); end
    if (b_level !== 3'd0) begin n_err++; $display("FAIL sat_level: got %0d, required 0", b_level); end
    for (int i = 0; i < 2 && gb + i < got_b_q.size(); i++) begin
      n_vec++;
      if (got_b_q[gb + i] !== exp_b[i]) begin n_err++; $display("FAIL sat_tok%0d: got %h, required %h", i, got_b_q[gb + i], exp_b[i]); end
    end
  endtask

  task automatic test_backpressure();
    int gb = got_q.size();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_pixel(i % 2, i == 0, i == 7);
      end
      begin
        repeat (10) @(negedge clk);
        n_vec += 2;
        if (fifo_level !== 3'd4) begin n_err++; $display("FAIL bp_level: got %0d, required 4", fifo_level); end
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %0d, required 0", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    n_vec++;
    if (got_q.size() - gb != exp_q.size()) begin n_err++; $display("FAIL bp_count: got %0d, required %0d", got_q.size() - gb, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[gb + i] !== exp_q[i]) begin n_err++; $display("FAIL bp_tok%0d: got %h, required %h", i, got_q[gb + i], exp_q[i]); end
    end
    model_reset();
  endtask

  task automatic test_sop_error();
    int gb = got_q.size(); int eb = err_pulses;
    for (int i = 0; i < 5; i++) send_pixel(2, i == 0, 0);
    for (int i = 0; i < 8; i++) send_pixel(1, i == 0, 0);
    send_pixel(0, 0, 1);
    drain();
    n_vec += 2;
    if (got_q.size() - gb != exp_q.size()) begin n_err++; $display("FAIL sop_count: got %0d, required %0d", got_q.size() - gb, exp_q.size()); end
    if (err_pulses - eb != 1) begin n_err++; $display("FAIL sop_frame_err: got %0d cycles high, required 1", err_pulses - eb); end
    for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[gb + i] !== exp_q[i]) begin n_err++; $display("FAIL sop_tok%0d: got %h, required %h", i, got_q[gb + i], exp_q[i]); end
    end
    model_reset();
  endtask

  task automatic test_single();
    int gb = got_q.size();
    send_pixel(1, 1, 1);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL single_flush_ready: got %0d, required 0", in_ready); end
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_back: got %0d, required 1", in_ready); end
    drain();
    n_vec++;
    if (got_q.size() - gb != 1) begin n_err++; $display("FAIL single_count: got %0d, required 1", got_q.size() - gb); end
    else begin
      n_vec++;
      if (got_q[gb] !== mk(1, 1, 1, 1)) begin n_err++; $display("FAIL single_tok: got %h, required %h", got_q[gb], mk(1, 1, 1, 1)); end
    end
    model_reset();
  endtask

  task automatic test_reset_mid();
    int gb;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_pixel(i, i == 0, 0);
    in_valid = 1'b0; in_sop = 1'b0;
    n_vec++;
    if (fifo_level !== 3'd3) begin n_err++; $display("FAIL rmid_pre_level: got %0d, required 3", fifo_level); end
    #2 rst_n = 1'b0;
    #1;
    n_vec += 2;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid: got %0d, required 0", out_valid); end
    if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rmid_level: got %0d, required 0", fifo_level); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    gb = got_q.size();
    send_line_frame();
    n_vec++;
    if (got_q.size() - gb != exp_q.size()) begin n_err++; $display("FAIL rmid_count: got %0d, required %0d", got_q.size() - gb, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[gb + i] !== exp_q[i]) begin n_err++; $display("FAIL rmid_tok%0d: got %h, required %h", i, got_q[gb + i], exp_q[i]); end
    end
    model_reset();
  endtask

  task automatic test_random();
    int gb = got_q.size(); int eb = err_pulses;
    bit done = 0;
    fork
      begin
        int s = 0;
        for (int f = 0; f < 12; f++) begin
          int len = $urandom_range(1, 24);
          for (int i = 0; i < len; i++) begin
            bit sop = (i == 0) || ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) s = $urandom_range(0, 3);
            send_pixel(s, sop, i == len - 1);
            if ($urandom_range(0, 4) == 0) begin
              in_valid = 1'b0;
              repeat ($urandom_range(1, 3)) @(posedge clk);
              #1;
            end
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    n_vec += 2;
    if (got_q.size() - gb != exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d, required %0d", got_q.size() - gb, exp_q.size()); end
    if (err_pulses - eb != exp_err) begin n_err++; $display("FAIL rand_frame_err: got %0d, required %0d", err_pulses - eb, exp_err); end
    for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[gb + i] !== exp_q[i]) begin n_err++; $display("FAIL rand_tok%0d: got %h, required %h", i, got_q[gb + i], exp_q[i]); end
    end
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_sym = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;
    b_sym = '0; b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0; b_out_ready = 1'b1;
    model_reset();
    test_reset();
    test_line();
    test_line_cut();
    test_saturation();
    test_backpressure();
    test_sop_error();
    test_single();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
